// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage.
// Owns the PC and keeps at most one read outstanding to instruction memory.
// Each fetched word goes to decode over a valid/ready pair.
// Redirects from execute are handled with a drop flag, so a stale in-flight
// response is discarded.
// Halt parks the unit once any open memory transaction has completed.
// Optional feature: define IFU_PERF_CNT_EN to add the fetch and stall counters.
module inst_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            busy,
  output logic            fault
`ifdef IFU_PERF_CNT_EN
  ,output logic [31:0]    perf_fetch_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_HALTED, S_FAULT} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] req_addr;   // held separately so a redirect cannot disturb a pending request
  logic            req_vld;
  logic            drop;       // the outstanding response belongs to a stale path
  logic            halt_pend;  // halt seen while a transaction was open
  logic            active;
  logic            redir;
  logic            req_fire;
  logic            hold_fire;

  assign active    = (state == S_REQ) || (state == S_WAIT) || (state == S_HOLD);
  assign redir     = redirect_valid && !halt && active;  // halt wins over redirect
  assign req_fire  = (state == S_REQ) && req_vld && imem_req_ready;
  assign hold_fire = (state == S_HOLD) && inst_ready;

  assign imem_req_valid = req_vld;
  assign imem_req_addr  = req_addr;
  assign busy           = active;

  // Next PC: a redirect overrides the sequential +4 taken on a decode handshake
  always_comb begin
    pc_nxt = pc;
    if (hold_fire) pc_nxt = pc + XLEN'(4);
    if (redir)     pc_nxt = redirect_pc;
  end

  // Fetch FSM with registered request and instruction outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      req_vld    <= 1'b0;
      drop       <= 1'b0;
      halt_pend  <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fault      <= 1'b0;
    end else begin
      pc <= pc_nxt;
      case (state)
        S_REQ: begin
          req_vld <= 1'b1;
          if (req_fire) begin
            state   <= S_WAIT;
            req_vld <= 1'b0;
            if (halt)  halt_pend <= 1'b1;
            if (redir) drop      <= 1'b1;
          end else if (halt) begin
            state   <= S_HALTED;
            req_vld <= 1'b0;
          end else if (redir) begin
            drop <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            drop <= 1'b0;
            if (halt || halt_pend) begin
              state <= S_HALTED;
            end else if (drop || redir) begin
              state    <= S_REQ;
              req_vld  <= 1'b1;
              req_addr <= pc_nxt;
            end else if (imem_resp_err) begin
              state   <= S_FAULT;
              fault   <= 1'b1;
              inst_pc <= req_addr;
            end else begin
              state      <= S_HOLD;
              inst       <= imem_resp_data;
              inst_pc    <= req_addr;
              inst_valid <= 1'b1;
            end
          end else begin
            if (halt)  halt_pend <= 1'b1;
            if (redir) drop      <= 1'b1;
          end
        end
        S_HOLD: begin
          if (halt) begin
            state      <= S_HALTED;
            inst_valid <= 1'b0;
          end else if (inst_ready || redir) begin
            state      <= S_REQ;
            inst_valid <= 1'b0;
            req_vld    <= 1'b1;
            req_addr   <= pc_nxt;
          end
        end
        default: ;  // HALTED and FAULT are terminal until reset
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Performance counters: decode handshakes and cycles spent waiting on memory
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (hold_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (((state == S_REQ) && !imem_req_ready) || (state == S_WAIT))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage: owns the PC, issues single-outstanding reads to instruction memory, and hands each fetched 32-bit instruction to the decode/control stage over a valid/ready interface.
- Producer end of the decoder's instruction input; also accepts PC redirects from execute and a halt request from decode (ebreak).

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk input 1 — single clock; all state updates on rising edge.
- rst_n input 1 — asynchronous, active-low reset.
- imem_req_valid output 1 — read request valid.
- imem_req_addr output XLEN — read address (= pc).
- imem_req_ready input 1 — memory accepts request.
- imem_resp_valid input 1 — read data valid.
- imem_resp_data input XLEN — instruction word.
- imem_resp_err input 1 — access fault, qualified by imem_resp_valid.
- inst_valid output 1 — instruction available to decode.
- inst output XLEN — instruction word.
- inst_pc output XLEN — PC of inst.
- inst_ready input 1 — decode consumes inst.
- redirect_valid input 1 — PC redirect (branch/jump).
- redirect_pc input XLEN — redirect target.
- halt input 1 — stop fetching (ebreak).
- busy output 1 — high in REQ/WAIT/HOLD.
- fault output 1 — sticky fetch-fault flag.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=REQ, drop=0; inst_valid=0, inst=0, inst_pc=0, fault=0. imem_req_valid goes 1 from the first edge after release.
- States: REQ, WAIT, HOLD, HALTED, FAULT.
- REQ: imem_req_valid=1, imem_req_addr=pc. Valid and addr remain stable until imem_req_ready=1, then go to WAIT.
- WAIT: imem_req_valid=0, one request outstanding.
  - On imem_resp_valid with drop=1: discard the response, clear drop, go to REQ.
  - On imem_resp_valid with err=1 and drop=0: fault=1, go to FAULT.
  - Otherwise: latch inst=data and inst_pc=pc, inst_valid=1, go to HOLD.
- HOLD: inst_valid=1; inst and inst_pc stable. On inst_ready: pc=pc+4 (mod 2^XLEN, wraps at 32'hFFFF_FFFC→0), inst_valid=0, go to REQ.
- Fetch latency: request accepted at edge N, response at edge M → inst_valid high from edge M; minimum 2 cycles from request to inst_valid.
- redirect_valid (priority over sequential pc update):
  - Any state except HALTED/FAULT: pc=redirect_pc.
  - REQ without ready: the current request is kept stable; set drop; the in-flight address is discarded later. REQ with ready: go to WAIT with drop=1.
  - WAIT: set drop (response discarded). If the response arrives in the same cycle, discard it and go to REQ.
  - HOLD: inst_valid=0 next cycle; go to REQ. Redirect plus inst_ready in the same cycle: the handshake counts, pc=redirect_pc (not +4).
  - No alignment check; redirect_pc[1:0] is forwarded unchanged.
- halt (sampled each edge):
  - REQ without ready, or HOLD: go to HALTED. HOLD with inst_ready in the same cycle counts the handshake.
  - REQ with ready, or WAIT: finish the transaction, discard the response, then go to HALTED.
  - halt beats redirect in the same cycle.
- HALTED and FAULT: imem_req_valid=0, inst_valid=0, busy=0. Only reset exits. In FAULT, inst_pc holds the faulting pc.
- Reset mid-transaction: all state clears immediately. A late imem_resp_valid arriving in REQ or after reset is ignored.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0.
  - perf_fetch_cnt increments on each inst_valid&&inst_ready handshake.
  - perf_stall_cnt increments each cycle in REQ with !imem_req_ready, or in WAIT.
  - Both wrap at 2^32.
- Undefined: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, memory always ready with 1-cycle response, inst_ready=1 → addrs 8000_0000, 8000_0004, 8000_0008; inst_pc matches each addr; one instruction per 3 cycles.
- HOLD with inst_ready=0 for 5 cycles, data 32'h0010_0093 → inst/inst_pc stable for all 5 cycles, no new request; after ready, next addr = +4.
- redirect_valid, redirect_pc=8000_0100 while in WAIT → response discarded (inst_valid stays 0); next request addr=8000_0100.
- In HOLD, redirect_pc=8000_0040 and inst_ready in the same cycle → next addr 8000_0040, not pc+4.
- halt asserted in WAIT → response discarded, HALTED; imem_req_valid=0 and busy=0 permanently, redirect ignored.
- imem_resp_err=1 at pc 8000_0008 → fault=1 sticky, inst_pc=8000_0008, no further requests. With IFU_PERF_CNT_EN: perf_fetch_cnt=2 after two handshakes.
